pipe_stall_ctrl: RTL and testbench

Central stall/flush scheduler for the 5-stage pipeline. It arbitrates the four sources that must freeze or bubble pipeline registers: data-memory wait, multi-cycle mul/div occupancy of EX, taken-branch redirect, and load-use hazard (the hazard detector's stall request). It generates the PC and pipeline-register write enables and flushes, and sequences the mul/div occupancy with an internal FSM and counter. It also tracks memory-wait timeouts and total stall cycles.

---
 rtl/pipe_stall_ctrl.sv | 171 +++++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush scheduler: arbitrates memory wait, mul/div occupancy, branch redirect
// and load-use hazard into register write enables and bubbles; tracks timeouts and stalls.
module pipe_stall_ctrl #(
   parameter int unsigned MD_LATENCY  = 4,
   parameter int unsigned MEM_TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        lu_stall,
   input  logic        br_taken,
   input  logic        md_start,
   input  logic        dmem_req,
   input  logic        dmem_ack,
   output logic        pc_we,
   output logic        ifid_we,
   output logic        idex_we,
   output logic        exmem_we,
   output logic        memwb_we,
   output logic        ifid_flush,
   output logic        idex_flush,
   output logic        exmem_flush,
   output logic        memwb_flush,
   output logic        md_busy,
   output logic        md_done,
   output logic        mem_err,
   output logic [15:0] stall_cycles
);

   localparam logic StRun    = 1'b0;
   localparam logic StMdWait = 1'b1;

   localparam logic [3:0] MdLoad    = 4'(MD_LATENCY - 2);
   localparam logic [7:0] MemErrCnt = 8'(MEM_TIMEOUT - 1);

   localparam logic [4:0] ActNone = 5'b00001;
   localparam logic [4:0] ActLu   = 5'b00010;
   localparam logic [4:0] ActBr   = 5'b00100;
   localparam logic [4:0] ActMd   = 5'b01000;
   localparam logic [4:0] ActMem  = 5'b10000;

   logic        state_q, state_d;
   logic [3:0]  md_cnt_q, md_cnt_d;
   logic [7:0]  mem_wait_cnt_q, mem_wait_cnt_d;
   logic        mem_err_q, mem_err_d;
   logic [15:0] stall_cycles_q, stall_cycles_d;

   logic       mem_stall;
   logic       md_stall;
   logic       in_run;
   logic       md_zero;
   logic [4:0] act;

   assign mem_stall = dmem_req & ~dmem_ack;
   assign in_run    = (state_q == StRun);
   assign md_zero   = (md_cnt_q == 4'd0);

   // In MD_WAIT the unit holds EX until the count expires and MEM is free to accept it.
   assign md_stall = (in_run & md_start) | (~in_run & (~md_zero | mem_stall));
   assign md_busy  = md_stall;
   assign md_done  = ~in_run & md_zero & ~mem_stall;

   always_comb begin
      act = ActNone;
      if (mem_stall) begin
         act = ActMem;
      end else if (md_stall) begin
         act = ActMd;
      end else if (br_taken) begin
         act = ActBr;
      end else if (lu_stall) begin
         act = ActLu;
      end
   end

   always_comb begin
      pc_we       = 1'b1;
      ifid_we     = 1'b1;
      idex_we     = 1'b1;
      exmem_we    = 1'b1;
      memwb_we    = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      memwb_flush = 1'b0;
      unique case (act)
         ActMem: begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_we     = 1'b0;
            exmem_we    = 1'b0;
            memwb_flush = 1'b1;
         end
         ActMd: begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_we     = 1'b0;
            exmem_flush = 1'b1;
         end
         ActBr: begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
         end
         ActLu: begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // The counter keeps running under a memory stall; only the release waits for MEM.
   always_comb begin
      state_d  = state_q;
      md_cnt_d = md_cnt_q;
      case (state_q)
         StRun: begin
            if (md_start && !mem_stall) begin
               state_d  = StMdWait;
               md_cnt_d = MdLoad;
            end
         end
         StMdWait: begin
            if (!md_zero) begin
               md_cnt_d = md_cnt_q - 4'd1;
            end else if (!mem_stall) begin
               state_d = StRun;
            end
         end
         default: state_d = StRun;
      endcase
   end

   always_comb begin
      mem_wait_cnt_d = 8'd0;
      if (mem_stall) begin
         mem_wait_cnt_d = (mem_wait_cnt_q == 8'hFF) ? mem_wait_cnt_q : mem_wait_cnt_q + 8'd1;
      end
   end

   // Visible in the same cycle the wait count hits the threshold, then held by the flop.
   assign mem_err   = mem_err_q | (mem_stall & (mem_wait_cnt_q == MemErrCnt));
   assign mem_err_d = mem_err;

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if (!pc_we && (stall_cycles_q != 16'hFFFF)) begin
         stall_cycles_d = stall_cycles_q + 16'd1;
      end
   end

   assign stall_cycles = stall_cycles_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= StRun;
         md_cnt_q       <= 4'd0;
         mem_wait_cnt_q <= 8'd0;
         mem_err_q      <= 1'b0;
         stall_cycles_q <= 16'd0;
      end else begin
         state_q        <= state_d;
         md_cnt_q       <= md_cnt_d;
         mem_wait_cnt_q <= mem_wait_cnt_d;
         mem_err_q      <= mem_err_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: decode table plus mul/div, memory-wait,
// async-reset and timeout sequences, checked through an expected-value queue.
module tb_pipe_stall_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        lu_stall = 1'b0;
   logic        br_taken = 1'b0;
   logic        md_start = 1'b0;
   logic        dmem_req = 1'b0;
   logic        dmem_ack = 1'b0;
   logic        pc_we, ifid_we, idex_we, exmem_we, memwb_we;
   logic        ifid_flush, idex_flush, exmem_flush, memwb_flush;
   logic        md_busy, md_done, mem_err;
   logic [15:0] stall_cycles;

   pipe_stall_ctrl #(
      .MD_LATENCY (4),
      .MEM_TIMEOUT(4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .lu_stall    (lu_stall),
      .br_taken    (br_taken),
      .md_start    (md_start),
      .dmem_req    (dmem_req),
      .dmem_ack    (dmem_ack),
      .pc_we       (pc_we),
      .ifid_we     (ifid_we),
      .idex_we     (idex_we),
      .exmem_we    (exmem_we),
      .memwb_we    (memwb_we),
      .ifid_flush  (ifid_flush),
      .idex_flush  (idex_flush),
      .exmem_flush (exmem_flush),
      .memwb_flush (memwb_flush),
      .md_busy     (md_busy),
      .md_done     (md_done),
      .mem_err     (mem_err),
      .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   // {pc,ifid,idex,exmem,memwb _we | ifid,idex,exmem,memwb _flush | md_busy, md_done}
   logic [10:0] outs;
   assign outs = {pc_we, ifid_we, idex_we, exmem_we, memwb_we,
                  ifid_flush, idex_flush, exmem_flush, memwb_flush, md_busy, md_done};

   localparam logic [10:0] ENone   = 11'b11111_0000_00;
   localparam logic [10:0] EMem    = 11'b00001_0001_00;
   localparam logic [10:0] EMemMd  = 11'b00001_0001_10;
   localparam logic [10:0] EMd     = 11'b00011_0010_10;
   localparam logic [10:0] EBr     = 11'b11111_1100_00;
   localparam logic [10:0] ELu     = 11'b00111_0100_00;
   localparam logic [10:0] EDone   = 11'b11111_0000_01;

   // Input vector order: {lu_stall, br_taken, md_start, dmem_req, dmem_ack}
   typedef struct {
      string       name;
      logic [4:0]  in;
      logic [10:0] exp;
   } vec_t;

   int          n_vec = 0;
   int          n_err = 0;
   logic [10:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [4:0] in);
      {lu_stall, br_taken, md_start, dmem_req, dmem_ack} = in;
   endtask

   task automatic apply(input string name, input logic [4:0] in, input logic [10:0] exp);
      @(posedge clk);
      #1;
      drive(in);
      exp_q.push_back(exp);
      @(negedge clk);
      check(name, 32'(outs), 32'(exp_q.pop_front()));
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      drive(5'b0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic check_stalls(input string name, input int exp);
      @(posedge clk);
      #1;
      drive(5'b0);
      @(negedge clk);
      check(name, 32'(stall_cycles), 32'(exp));
   endtask

   vec_t tbl[10];
   int   exp_stalls;

   initial begin
      tbl[0] = '{"idle",        5'b00000, ENone};
      tbl[1] = '{"br",          5'b01000, EBr};
      tbl[2] = '{"lu",          5'b10000, ELu};
      tbl[3] = '{"br_lu",       5'b11000, EBr};
      tbl[4] = '{"br_lu_mem",   5'b11010, EMem};
      tbl[5] = '{"req_ack",     5'b00011, ENone};
      tbl[6] = '{"ack_only",    5'b00001, ENone};
      tbl[7] = '{"lu_req_ack",  5'b10011, ELu};
      tbl[8] = '{"mem",         5'b00010, EMem};
      tbl[9] = '{"br_req_ack",  5'b01011, EBr};

      // Reset state with all inputs low
      #2;
      check("rst_outs", 32'(outs), 32'(ENone));
      check("rst_mem_err", 32'(mem_err), 32'd0);
      check("rst_stalls", 32'(stall_cycles), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      exp_stalls = 0;
      for (int i = 0; i < 10; i++) begin
         apply(tbl[i].name, tbl[i].in, tbl[i].exp);
         if (!tbl[i].exp[10]) exp_stalls++;
      end
      check_stalls("tbl_stalls", exp_stalls);

      // Mul/div, latency 4, no memory wait
      do_reset();
      apply("md_t0", 5'b00100, EMd);
      apply("md_t1", 5'b00100, EMd);
      apply("md_t2", 5'b00100, EMd);
      apply("md_t3", 5'b00100, EDone);
      apply("md_t4", 5'b00000, ENone);
      check_stalls("md_stalls", 3);

      // Memory wait overlapping mul/div: release held until ack
      do_reset();
      apply("mdm_t0", 5'b00100, EMd);
      apply("mdm_t1", 5'b00110, EMemMd);
      apply("mdm_t2", 5'b00110, EMemMd);
      apply("mdm_t3", 5'b00110, EMemMd);
      apply("mdm_t4", 5'b00110, EMemMd);
      apply("mdm_t5", 5'b00111, EDone);
      apply("mdm_t6", 5'b00000, ENone);
      check_stalls("mdm_stalls", 5);

      // md_start under a memory stall in RUN retries without starting the count
      do_reset();
      apply("mdr_t0", 5'b00110, EMemMd);
      apply("mdr_t1", 5'b00111, EMd);
      apply("mdr_t2", 5'b00100, EMd);
      apply("mdr_t3", 5'b00100, EMd);
      apply("mdr_t4", 5'b00100, EDone);
      apply("mdr_t5", 5'b00000, ENone);

      // Asynchronous reset mid-MD_WAIT abandons the operation
      do_reset();
      apply("mda_t0", 5'b00100, EMd);
      apply("mda_t1", 5'b00100, EMd);
      @(posedge clk);
      #2;
      md_start = 1'b0;
      rst_n = 1'b0;
      #1;
      check("async_rst", 32'(outs), 32'(ENone));
      @(negedge clk);
      rst_n = 1'b1;
      apply("mdb_t0", 5'b00100, EMd);
      apply("mdb_t1", 5'b00100, EMd);
      apply("mdb_t2", 5'b00100, EMd);
      apply("mdb_t3", 5'b00100, EDone);

      // Memory timeout at 4 consecutive wait cycles, sticky until reset
      do_reset();
      for (int w = 1; w <= 6; w++) begin
         apply("to_outs", 5'b00010, EMem);
         check($sformatf("to_err_w%0d", w), 32'(mem_err), (w >= 4) ? 32'd1 : 32'd0);
      end
      apply("to_ack", 5'b00011, ENone);
      check("to_err_ack", 32'(mem_err), 32'd1);
      apply("to_idle", 5'b00000, ENone);
      check("to_err_idle", 32'(mem_err), 32'd1);
      do_reset();
      @(negedge clk);
      check("to_err_rst", 32'(mem_err), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
